// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run-control / halt-detection monitor for the single-cycle MIPS core
// Optional RF-write signature register is built only when MON_RF_SIG_EN is defined.
module cpu_run_monitor #(
    parameter int          PC_W        = 32,
    parameter int          CNT_W       = 16,
    parameter int          MAX_CYCLES  = 200,
    parameter int          HALT_REPEAT = 4,
    parameter logic [31:0] HALT_INST   = 32'h0000000C,
    parameter int          RF_AW       = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [31:0]      inst_i,
    input  logic             rf_we_i,
    input  logic [RF_AW-1:0] rf_waddr_i,
    input  logic [31:0]      rf_wdata_i,
    output logic             running_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] inst_cnt_o,
    output logic [PC_W-1:0]  halt_pc_o,
    output logic [31:0]      sig_o
);

    // same_cnt only needs to reach HALT_REPEAT-1 before the run freezes
    localparam int SC_W = (HALT_REPEAT > 2) ? $clog2(HALT_REPEAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t            state_q;
    logic              running_q;
    logic              done_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  inst_cnt_q;
    logic [PC_W-1:0]   halt_pc_q;
    logic [PC_W-1:0]   pc_prev_q;
    logic              prev_vld_q;
    logic [SC_W-1:0]   same_cnt_q;

    logic              same_pc;
    logic              halt_det;
    logic              tmo_det;
    logic              inst_counts;

    always_comb begin
        same_pc     = prev_vld_q && (pc_i == pc_prev_q);
        halt_det    = (inst_i == HALT_INST) ||
                      (same_pc && (same_cnt_q == SC_W'(HALT_REPEAT - 2)));
        tmo_det     = !halt_det && ((cycle_cnt_q + CNT_W'(1)) == CNT_W'(MAX_CYCLES));
        inst_counts = (inst_i != 32'h0) && (inst_i != HALT_INST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            halt_pc_q   <= '0;
            pc_prev_q   <= '0;
            prev_vld_q  <= 1'b0;
            same_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    if (inst_counts) begin
                        inst_cnt_q <= inst_cnt_q + CNT_W'(1);
                    end
                    pc_prev_q  <= pc_i;
                    prev_vld_q <= 1'b1;
                    same_cnt_q <= same_pc ? same_cnt_q + SC_W'(1) : '0;
                    // halt has priority over a coincident timeout
                    if (halt_det) begin
                        state_q   <= S_HALTED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        halt_pc_q <= pc_i;
                    end else if (tmo_det) begin
                        state_q   <= S_TIMEOUT;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        halt_pc_q <= pc_i;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q     <= S_RUN;
                        running_q   <= 1'b1;
                        done_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        cycle_cnt_q <= '0;
                        inst_cnt_q  <= '0;
                        halt_pc_q   <= '0;
                        pc_prev_q   <= '0;
                        prev_vld_q  <= 1'b0;
                        same_cnt_q  <= '0;
                    end
                end
            endcase
        end
    end

    assign running_o   = running_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign inst_cnt_o  = inst_cnt_q;
    assign halt_pc_o   = halt_pc_q;

`ifdef MON_RF_SIG_EN
    logic [31:0] sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else if (state_q == S_RUN) begin
            if (rf_we_i && (rf_waddr_i != '0)) begin
                sig_q <= {sig_q[30:0], sig_q[31]} ^ rf_wdata_i ^
                         {{(32-RF_AW){1'b0}}, rf_waddr_i};
            end
        end else if (start_i) begin
            sig_q <= '0;
        end
    end

    assign sig_o = sig_q;
`else
    logic sig_unused;
    assign sig_unused = &{1'b0, rf_we_i, rf_waddr_i, rf_wdata_i};
    assign sig_o      = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - self-checking bench for cpu_run_monitor against a cycle-list reference model
module tb_cpu_run_monitor;

    localparam int          PC_W     = 32;
    localparam int          CNT_W    = 16;
    localparam int          MAX_CYC  = 200;
    localparam int          HALT_REP = 4;
    localparam logic [31:0] HALT_I   = 32'h0000000C;
    localparam int          RF_AW    = 5;
    localparam int          NMAX     = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PC_W-1:0]  pc;
    logic [31:0]      inst;
    logic             we;
    logic [RF_AW-1:0] wa;
    logic [31:0]      wd;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] inst_cnt;
    logic [PC_W-1:0]  halt_pc;
    logic [31:0]      sig;

    int checks   = 0;
    int failures = 0;

    // per-RUN-cycle stimulus program, index 1 = first RUN cycle
    logic [31:0]      s_pc   [NMAX];
    logic [31:0]      s_inst [NMAX];
    logic             s_we   [NMAX];
    logic [RF_AW-1:0] s_wa   [NMAX];
    logic [31:0]      s_wd   [NMAX];
    logic             s_start[NMAX];

    int          e_cyc;
    int          e_inst;
    logic        e_to;
    logic [31:0] e_hpc;
    logic [31:0] e_sig;

    cpu_run_monitor #(
        .PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYC),
        .HALT_REPEAT(HALT_REP), .HALT_INST(HALT_I), .RF_AW(RF_AW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc), .inst_i(inst),
        .rf_we_i(we), .rf_waddr_i(wa), .rf_wdata_i(wd),
        .running_o(running), .done_o(done), .timeout_o(timeout),
        .cycle_cnt_o(cycle_cnt), .inst_cnt_o(inst_cnt), .halt_pc_o(halt_pc), .sig_o(sig)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int k = 0; k < NMAX; k++) begin
            s_pc[k]    = (k == 0) ? 32'h0 : 32'((k - 1) * 4);
            s_inst[k]  = 32'h2000_0000 | 32'(k);
            s_we[k]    = 1'b0;
            s_wa[k]    = '0;
            s_wd[k]    = '0;
            s_start[k] = 1'b0;
        end
    endtask

    // Walk the program cycle by cycle: halt on HALT_INST or a PC run of HALT_REP, else time out.
    task automatic model();
        int run_len;
        run_len = 0;
        e_cyc = 0; e_inst = 0; e_to = 1'b0; e_hpc = '0; e_sig = '0;
        for (int k = 1; k <= MAX_CYC; k++) begin
            e_cyc   = k;
            run_len = (k > 1 && s_pc[k] == s_pc[k-1]) ? run_len + 1 : 1;
            if (s_inst[k] != 0 && s_inst[k] != HALT_I) e_inst++;
`ifdef MON_RF_SIG_EN
            if (s_we[k] && s_wa[k] != 0)
                e_sig = {e_sig[30:0], e_sig[31]} ^ s_wd[k] ^ 32'(s_wa[k]);
`endif
            if (s_inst[k] == HALT_I || run_len >= HALT_REP) begin
                e_hpc = s_pc[k];
                break;
            end
            if (k == MAX_CYC) begin
                e_to  = 1'b1;
                e_hpc = s_pc[k];
            end
        end
    endtask

    task automatic run_prog(input string name);
        int k;
        k = 0;
        model();
        start = 1'b1; pc = '0; inst = '0; we = 1'b0; wa = '0; wd = '0;
        step();
        start = 1'b0;
        checks++;
        if (running !== 1'b1 || cycle_cnt !== 0) begin
            failures++;
            $display("FAIL %s.start got running=%0b cycle_cnt=%0d exp running=1 cycle_cnt=0", name, running, cycle_cnt);
        end
        while (done !== 1'b1 && k < MAX_CYC + 4) begin
            k++;
            pc = s_pc[k]; inst = s_inst[k]; we = s_we[k]; wa = s_wa[k]; wd = s_wd[k]; start = s_start[k];
            step();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || k != e_cyc) begin
            failures++;
            $display("FAIL %s.done_at got done=%0b cycle=%0d exp done=1 cycle=%0d", name, done, k, e_cyc);
        end
        // outputs must freeze while inputs keep toggling
        for (int h = 0; h < 5; h++) begin
            checks++;
            if (running !== 1'b0 || done !== 1'b1 || timeout !== e_to || cycle_cnt !== CNT_W'(e_cyc) ||
                inst_cnt !== CNT_W'(e_inst) || halt_pc !== e_hpc || sig !== e_sig) begin
                failures++;
                $display("FAIL %s.final[%0d] got run=%0b done=%0b to=%0b cyc=%0d inst=%0d hpc=%h sig=%h exp run=0 done=1 to=%0b cyc=%0d inst=%0d hpc=%h sig=%h",
                         name, h, running, done, timeout, cycle_cnt, inst_cnt, halt_pc, sig,
                         e_to, e_cyc, e_inst, e_hpc, e_sig);
            end
            pc = $urandom; inst = ($urandom % 2) ? HALT_I : $urandom;
            we = 1'b1; wa = RF_AW'($urandom | 1); wd = $urandom;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({running, done, timeout} !== 3'b0 || cycle_cnt !== 0 || inst_cnt !== 0 || halt_pc !== 0 || sig !== 0) begin
            failures++;
            $display("FAIL reset got run=%0b done=%0b to=%0b cyc=%0d inst=%0d hpc=%h sig=%h exp all 0",
                     running, done, timeout, cycle_cnt, inst_cnt, halt_pc, sig);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_halt_inst();
        clear_prog();
        s_inst[13] = HALT_I;
        run_prog("halt_inst");
        checks++;
        if (halt_pc !== 32'h30 || cycle_cnt !== 13 || inst_cnt !== 12 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL halt_inst.fixed got hpc=%h cyc=%0d inst=%0d to=%0b exp hpc=30 cyc=13 inst=12 to=0",
                     halt_pc, cycle_cnt, inst_cnt, timeout);
        end
    endtask

    task automatic test_pc_stuck();
        clear_prog();
        for (int k = 1; k < NMAX; k++) if (s_pc[k] > 32'h20) s_pc[k] = 32'h20;
        run_prog("pc_stuck");
        checks++;
        if (halt_pc !== 32'h20 || cycle_cnt !== 12 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL pc_stuck.fixed got hpc=%h cyc=%0d to=%0b exp hpc=20 cyc=12 to=0", halt_pc, cycle_cnt, timeout);
        end
    endtask

    task automatic test_timeout();
        clear_prog();
        run_prog("timeout");
        checks++;
        if (timeout !== 1'b1 || done !== 1'b1 || running !== 1'b0 || cycle_cnt !== 200) begin
            failures++;
            $display("FAIL timeout.fixed got to=%0b done=%0b run=%0b cyc=%0d exp to=1 done=1 run=0 cyc=200",
                     timeout, done, running, cycle_cnt);
        end
    endtask

    task automatic test_halt_timeout_tie();
        clear_prog();
        s_inst[MAX_CYC] = HALT_I;
        run_prog("tie");
        checks++;
        if (timeout !== 1'b0 || cycle_cnt !== 200 || inst_cnt !== 199) begin
            failures++;
            $display("FAIL tie.fixed got to=%0b cyc=%0d inst=%0d exp to=0 cyc=200 inst=199", timeout, cycle_cnt, inst_cnt);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (running !== 1'b1 || done !== 1'b0 || timeout !== 1'b0 || cycle_cnt !== 0 || inst_cnt !== 0 || halt_pc !== 0) begin
            failures++;
            $display("FAIL tie.restart got run=%0b done=%0b to=%0b cyc=%0d inst=%0d hpc=%h exp run=1 done=0 to=0 cyc=0 inst=0 hpc=0",
                     running, done, timeout, cycle_cnt, inst_cnt, halt_pc);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_rst_mid_run();
        clear_prog();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            pc = s_pc[k]; inst = s_inst[k];
            if (k < 10) step();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({running, done, timeout} !== 3'b0 || cycle_cnt !== 0 || inst_cnt !== 0 || halt_pc !== 0 || sig !== 0) begin
            failures++;
            $display("FAIL rst_mid.async got run=%0b done=%0b to=%0b cyc=%0d inst=%0d exp all 0",
                     running, done, timeout, cycle_cnt, inst_cnt);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({running, done, timeout} !== 3'b0 || cycle_cnt !== 0) begin
            failures++;
            $display("FAIL rst_mid.idle got run=%0b done=%0b to=%0b cyc=%0d exp all 0", running, done, timeout, cycle_cnt);
        end
        s_inst[13] = HALT_I;
        run_prog("rst_rerun");
    endtask

    task automatic test_sig();
        logic [31:0] exp_sig;
        clear_prog();
        s_we[1] = 1'b1; s_wa[1] = 5'd8; s_wd[1] = 32'h1;
        s_we[2] = 1'b1; s_wa[2] = 5'd0; s_wd[2] = 32'hFFFF;
        s_we[3] = 1'b1; s_wa[3] = 5'd9; s_wd[3] = 32'h2;
        s_inst[4] = HALT_I;
        run_prog("sig");
`ifdef MON_RF_SIG_EN
        exp_sig = 32'h19;
`else
        exp_sig = 32'h0;
`endif
        checks++;
        if (sig !== exp_sig) begin
            failures++;
            $display("FAIL sig.fixed got %h exp %h", sig, exp_sig);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            clear_prog();
            for (int k = 1; k < NMAX; k++) begin
                if (k == 1) s_pc[k] = $urandom & 32'hFFFF_FFFC;
                else        s_pc[k] = ($urandom % 5 == 0) ? s_pc[k-1] : s_pc[k-1] + 4;
                case ($urandom % 64)
                    0:       s_inst[k] = 32'h0;
                    1:       s_inst[k] = HALT_I;
                    default: begin
                        s_inst[k] = $urandom;
                        if (s_inst[k] == HALT_I) s_inst[k] = 32'h1;
                    end
                endcase
                s_we[k]    = $urandom % 2;
                s_wa[k]    = RF_AW'($urandom);
                s_wd[k]    = $urandom;
                s_start[k] = ($urandom % 8 == 0);
            end
            run_prog($sformatf("random%0d", it));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc = '0; inst = '0; we = 1'b0; wa = '0; wd = '0;
        test_reset();
        test_halt_inst();
        test_pc_stuck();
        test_timeout();
        test_halt_timeout_tie();
        test_rst_mid_run();
        test_sig();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
